// File: rtl/mem_region_sequencer.sv
// Load/dump sequencer for four BRAM regions sharing one linear word space.
// Latency: load outputs registered (+1 cycle); dump first byte at start+2+READ_LATENCY.
// Backpressure: byte_out/byte_valid_out held until byte_ready_in; GAP cycle after each accept.
module mem_region_sequencer #(
  parameter int DEPTH0       = 25250,
  parameter int DEPTH1       = 25000,
  parameter int DEPTH2       = 50,
  parameter int DEPTH3       = 2500,
  parameter int READ_LATENCY = 2,
  localparam int TOTAL       = DEPTH0 + DEPTH1 + DEPTH2 + DEPTH3,
  localparam int AW          = $clog2(TOTAL + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          word_valid_in,
  input  logic [31:0]   word_in,
  input  logic          load_clear_in,
  output logic [3:0]    wr_en_out,
  output logic [AW-1:0] wr_addr_out,
  output logic [31:0]   wr_data_out,
  output logic [AW-1:0] load_count_out,
  output logic          load_done_out,
  input  logic          dump_start_in,
  input  logic          dump_abort_in,
  output logic [AW-1:0] rd_addr_out,
  output logic [1:0]    rd_region_out,
  input  logic [31:0]   rd_data0_in,
  input  logic [31:0]   rd_data1_in,
  input  logic [31:0]   rd_data2_in,
  input  logic [31:0]   rd_data3_in,
  output logic [7:0]    byte_out,
  output logic          byte_valid_out,
  input  logic          byte_ready_in,
  output logic          dump_busy_out,
  output logic          dump_done_out
);

  localparam logic [AW-1:0] C_B1    = AW'(DEPTH0);
  localparam logic [AW-1:0] C_B2    = AW'(DEPTH0 + DEPTH1);
  localparam logic [AW-1:0] C_B3    = AW'(DEPTH0 + DEPTH1 + DEPTH2);
  localparam logic [AW-1:0] C_TOTAL = AW'(TOTAL);
  localparam logic [AW-1:0] C_LAST  = AW'(TOTAL - 1);
  localparam int            LW      = $clog2(READ_LATENCY + 1);
  localparam logic [LW-1:0] C_RL    = LW'(READ_LATENCY);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_SEND, S_GAP, S_DONE} state_t;

  // Which region a linear word index falls into.
  function automatic logic [1:0] f_region(input logic [AW-1:0] p);
    logic [1:0] r;
    r = 2'd3;
    if (p < C_B3) r = 2'd2;
    if (p < C_B2) r = 2'd1;
    if (p < C_B1) r = 2'd0;
    return r;
  endfunction

  // Region-local address of a linear word index.
  function automatic logic [AW-1:0] f_local(input logic [AW-1:0] p);
    logic [AW-1:0] a;
    case (f_region(p))
      2'd0:    a = p;
      2'd1:    a = p - C_B1;
      2'd2:    a = p - C_B2;
      default: a = p - C_B3;
    endcase
    return a;
  endfunction

  logic [AW-1:0] r_ptr;
  logic [3:0]    r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [31:0]   r_wr_data;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_g;
  logic [LW-1:0] r_lat;
  logic [1:0]    r_idx;
  logic [31:0]   r_shift;
  logic [AW-1:0] r_rd_addr;
  logic [1:0]    r_rd_region;
  logic [31:0]   w_rd_data;
  logic          w_byte_valid;
  logic          w_busy;
  logic          w_done;

  // Load path: pointer, saturating at TOTAL; clear beats a same-cycle word.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ptr     <= '0;
      r_wr_en   <= 4'd0;
      r_wr_addr <= '0;
      r_wr_data <= 32'd0;
    end else begin
      r_wr_en <= 4'd0;
      if (load_clear_in) begin
        r_ptr <= '0;
      end else if (word_valid_in && (r_ptr != C_TOTAL)) begin
        r_wr_en   <= 4'b0001 << f_region(r_ptr);
        r_wr_addr <= f_local(r_ptr);
        r_wr_data <= word_in;
        r_ptr     <= r_ptr + AW'(1);
      end
    end
  end

  // Dump FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Dump FSM next state and state-decoded outputs; abort overrides everything.
  always_comb begin
    w_next       = r_state;
    w_byte_valid = 1'b0;
    w_busy       = (r_state != S_IDLE);
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: if (dump_start_in) w_next = S_ADDR;
      S_ADDR: w_next = S_WAIT;
      S_WAIT: if (r_lat <= LW'(1)) w_next = S_SEND;
      S_SEND: begin
        w_byte_valid = 1'b1;
        if (byte_ready_in) w_next = S_GAP;
      end
      S_GAP: begin
        if (r_idx != 2'd3)      w_next = S_SEND;
        else if (r_g != C_LAST) w_next = S_ADDR;
        else                    w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (dump_abort_in) w_next = S_IDLE;
  end

  // Read-data select for the region currently addressed.
  always_comb begin
    w_rd_data = rd_data0_in;
    case (r_rd_region)
      2'd1:    w_rd_data = rd_data1_in;
      2'd2:    w_rd_data = rd_data2_in;
      2'd3:    w_rd_data = rd_data3_in;
      default: w_rd_data = rd_data0_in;
    endcase
  end

  // Dump datapath: read index, latency count, capture and byte shifting.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_g         <= '0;
      r_lat       <= '0;
      r_idx       <= 2'd0;
      r_shift     <= 32'd0;
      r_rd_addr   <= '0;
      r_rd_region <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: r_g <= '0;
        S_ADDR: begin
          r_rd_region <= f_region(r_g);
          r_rd_addr   <= f_local(r_g);
          r_lat       <= C_RL;
        end
        S_WAIT: begin
          r_lat <= r_lat - LW'(1);
          if (r_lat <= LW'(1)) begin
            r_shift <= w_rd_data;
            r_idx   <= 2'd0;
          end
        end
        S_GAP: begin
          if (r_idx != 2'd3) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= {r_shift[23:0], 8'h00};
          end else if (r_g != C_LAST) begin
            r_g <= r_g + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_en_out      = r_wr_en;
  assign wr_addr_out    = r_wr_addr;
  assign wr_data_out    = r_wr_data;
  assign load_count_out = r_ptr;
  assign load_done_out  = (r_ptr == C_TOTAL);
  assign rd_addr_out    = r_rd_addr;
  assign rd_region_out  = r_rd_region;
  assign byte_out       = r_shift[31:24];
  assign byte_valid_out = w_byte_valid;
  assign dump_busy_out  = w_busy;
  assign dump_done_out  = w_done;

endmodule

// File: doc/mem_region_sequencer.md
# mem_region_sequencer

Controller that sequences the segmented parameter memory: four BRAM regions (weights, pt, sk, b) that share one linear word address space. On the load side it takes packed 32-bit words from the UART receive path, keeps the linear write pointer, and decodes it into per-region write enables and local addresses. On the dump side it walks every word of every region in order, absorbs the BRAM read latency, and serialises each word MSB-first into bytes for the UART transmitter under a valid/ready handshake.

## Interface
Parameters:
- DEPTH0, 25250: words in region 0 (32-bit weights)
- DEPTH1, 25000: words in region 1
- DEPTH2, 50: words in region 2
- DEPTH3, 2500: words in region 3
- READ_LATENCY, 2: clock cycles from rd_addr_out change to valid rd_dataN_in
- TOTAL (derived) = DEPTH0+DEPTH1+DEPTH2+DEPTH3; AW (derived) = $clog2(TOTAL+1)

Ports:
- clk_in  input  1  system clock; the only clock
- rst_in  input  1  reset, synchronous, active-high
- word_valid_in  input  1  one-cycle strobe: word_in is a new packed word
- word_in  input  32  packed load word
- load_clear_in  input  1  returns write pointer to 0
- wr_en_out  output  4  one-hot write enable, bit N = region N
- wr_addr_out  output  AW  region-local write address
- wr_data_out  output  32  write data
- load_count_out  output  AW  words written since reset/clear
- load_done_out  output  1  high while load_count_out == TOTAL
- dump_start_in  input  1  start a full dump
- dump_abort_in  input  1  abandon dump immediately
- rd_addr_out  output  AW  region-local read address (all port-A addresses)
- rd_region_out  output  2  region being read
- rd_data0_in..rd_data3_in  input  32 each  port-A read data, narrow regions zero-extended at top level
- byte_out  output  8  byte to transmitter
- byte_valid_out  output  1  byte_out valid
- byte_ready_in  input  1  transmitter can accept (top level drives !uart_busy)
- dump_busy_out  output  1  high in any state except IDLE
- dump_done_out  output  1  one-cycle pulse after last byte accepted

## Operation
- Reset: write pointer 0, wr_en_out 0, wr_addr_out 0, wr_data_out 0, load_count_out 0, load_done_out 0, state IDLE, rd_addr_out 0, rd_region_out 0, byte_out 0, byte_valid_out 0, dump_busy_out 0, dump_done_out 0.
- Load decode on pointer P: region 0 if P<DEPTH0, 1 if P<DEPTH0+DEPTH1, 2 if P<DEPTH0+DEPTH1+DEPTH2, else 3; local address = P minus that region's base.
- word_valid_in with P<TOTAL: write issued, P increments. With P==TOTAL: word dropped, wr_en_out stays 0, P holds (no wrap).
- load_clear_in: P←0; wins over a simultaneous word_valid_in (that word dropped).
- Load path runs independently of the dump FSM (port B vs port A); no arbitration between them.
- Dump FSM states: IDLE, ADDR, WAIT, SEND, GAP, DONE.
  - IDLE: dump_start_in → ADDR with global read index G=0.
  - ADDR: drive rd_region_out/rd_addr_out from G (same decode as load); → WAIT, latency counter = READ_LATENCY.
  - WAIT: count down; at expiry capture rd_dataN_in of rd_region_out into a 32-bit shift register, byte index 0; → SEND.
  - SEND: byte_valid_out=1, byte_out = captured[31:24] for index 0, [23:16], [15:8], [7:0]. On byte_valid_out && byte_ready_in → GAP.
  - GAP: one cycle with byte_valid_out=0 so transmitter busy can assert. Then: index<3 → index+1, SEND; index==3 and G<TOTAL-1 → G+1, ADDR; index==3 and G==TOTAL-1 → DONE.
  - DONE: dump_done_out=1 for one cycle; → IDLE.
- dump_start_in outside IDLE: ignored.
- dump_abort_in in any non-IDLE state: → IDLE next cycle, byte_valid_out 0, no dump_done_out. Abort wins over simultaneous start in IDLE (stays IDLE).
- Dump reads whatever is in the BRAMs regardless of load_count_out.

## Timing
- Load: word_valid_in at cycle t → wr_en_out/wr_addr_out/wr_data_out valid at t+1 (registered), for exactly one cycle; load_count_out updated at t+1.
- Dump: dump_start_in at t → ADDR at t+1 (rd_addr_out valid from t+2), WAIT cycles t+2..t+1+READ_LATENCY, capture at end of t+1+READ_LATENCY, first byte_valid_out at t+2+READ_LATENCY.
- Byte throughput with ready always high: one byte per 2 cycles (SEND+GAP); word overhead ADDR+READ_LATENCY cycles.
- byte_out stable and byte_valid_out held high until accepted.

## Test plan
- Load 3 words at P=DEPTH0-1 (DEPTH0=4, DEPTH1=2): wr_en_out 0001 addr 3, then 0010 addr 0, then 0010 addr 1.
- Fill to TOTAL, then one extra word_valid_in → wr_en_out stays 0, load_count_out == TOTAL, load_done_out 1.
- Dump with ready tied high, memories preloaded 0xA1B2C3D4 at word 0 → bytes A1,B2,C3,D4 in order, first valid at start+2+READ_LATENCY, dump_done_out after last of 4·TOTAL bytes.
- Ready held low 50 cycles in SEND → byte_out/byte_valid_out unchanged; no byte lost or repeated after release.
- dump_abort_in mid-word → IDLE next cycle, byte_valid_out 0, no dump_done_out; fresh start restarts at G=0.
- load_clear_in together with word_valid_in → no write, pointer 0; rst_in mid-dump → all outputs to reset values next cycle.
